mdu_seq: RTL

Multi-cycle multiply/divide sequencer for the execute stage. It owns the two-cycle multiply-accumulate/subtract flow and the start/ready handshake with the iterative divider. It raises the execute-stage stall request and produces the HI/LO write bundle (whilo/hi/lo). It holds a finished result until the execute stage actually advances, so stalls from later stages never re-issue an operation.

---
 rtl/mdu_seq_pkg.sv | 32 +++
 rtl/mdu_seq_mul32.sv | 25 ++
 rtl/mdu_seq.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the multiply/divide sequencer.
// Holds the MDU op encodings, the sequencer state encoding and the
// pipeline control constants reused by the execute stage.
package mdu_seq_pkg;

    // MDU operation encodings (op_i); 9..15 behave as MDU_NONE
    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_MADD  = 4'd3;
    localparam logic [3:0] MDU_MADDU = 4'd4;
    localparam logic [3:0] MDU_MSUB  = 4'd5;
    localparam logic [3:0] MDU_MSUBU = 4'd6;
    localparam logic [3:0] MDU_DIV   = 4'd7;
    localparam logic [3:0] MDU_DIVU  = 4'd8;

    // Pipeline control levels
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic Stop         = 1'b1;
    localparam logic NoStop       = 1'b0;
    localparam logic DivStart     = 1'b1;
    localparam logic DivStop      = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ACC      = 2'd1,
        S_DIV_WAIT = 2'd2,
        S_DONE     = 2'd3
    } mdu_state_e;

endpackage

// File: rtl/mdu_seq_mul32.sv
// Combinational 32x32 -> 64 multiplier, signed or unsigned.
// Ports: a_i/b_i operands, signed_i selects signed mode, prod_o 64-bit product.
// Latency 0; no handshake.
module mdu_seq_mul32 (
    input  logic        signed_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] prod_o
);
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] mag_p;
    logic        neg;

    // Signed mode multiplies magnitudes and negates the result when the
    // operand signs differ; 0x80000000 has magnitude 0x80000000, which the
    // unsigned multiply handles correctly.
    always_comb begin
        mag_a  = (signed_i && a_i[31]) ? (~a_i + 32'd1) : a_i;
        mag_b  = (signed_i && b_i[31]) ? (~b_i + 32'd1) : b_i;
        mag_p  = {32'd0, mag_a} * {32'd0, mag_b};
        neg    = signed_i && (a_i[31] ^ b_i[31]);
        prod_o = neg ? (~mag_p + 64'd1) : mag_p;
    end
endmodule

// File: rtl/mdu_seq.sv
// Execute-stage multiply/divide sequencer: MULT same cycle, MADD/MSUB two cycles, DIV via divider handshake.
// Latency: MULT 0, MADD/MSUB 1 stall cycle, DIV issue..ready-1 stall cycles.
// Backpressure: finished results held in DONE until ex_adv_i; annul_i aborts; rst forces all outputs low.
// Ports: op_i/opa_i/opb_i/hilo_i operation inputs, ex_adv_i/annul_i pipeline control,
//        stallreq_o/whilo_o/hi_o/lo_o results, div_* divider handshake.
module mdu_seq
    import mdu_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  op_i,
    input  logic [31:0] opa_i,
    input  logic [31:0] opb_i,
    input  logic [63:0] hilo_i,
    input  logic        ex_adv_i,
    input  logic        annul_i,
    output logic        stallreq_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        div_start_o,
    output logic        div_signed_o,
    output logic [31:0] div_opa_o,
    output logic [31:0] div_opb_o,
    output logic        div_annul_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i
);
    mdu_state_e  state_q, state_d;
    logic [63:0] prod_q, prod_d;
    logic [63:0] res_q, res_d;
    logic [31:0] dopa_q, dopa_d;
    logic [31:0] dopb_q, dopb_d;
    logic        dsgn_q, dsgn_d;

    logic        mul_signed;
    logic [63:0] product;
    logic [63:0] acc_sum;

    logic        stall_c, whilo_c, start_c, sgn_c, annul_c;
    logic [63:0] hilo_c;
    logic [31:0] opa_c, opb_c;

    assign mul_signed = (op_i == MDU_MULT) || (op_i == MDU_MADD) || (op_i == MDU_MSUB);
    assign acc_sum    = prod_q + hilo_i;

    mdu_seq_mul32 u_mul (
        .signed_i (mul_signed),
        .a_i      (opa_i),
        .b_i      (opb_i),
        .prod_o   (product)
    );

    always_comb begin
        state_d = state_q;
        prod_d  = prod_q;
        res_d   = res_q;
        dopa_d  = dopa_q;
        dopb_d  = dopb_q;
        dsgn_d  = dsgn_q;
        stall_c = NoStop;
        whilo_c = WriteDisable;
        start_c = DivStop;
        sgn_c   = 1'b0;
        annul_c = 1'b0;
        hilo_c  = 64'd0;
        opa_c   = 32'd0;
        opb_c   = 32'd0;

        if (annul_i) begin
            state_d = S_IDLE;
            annul_c = (state_q == S_DIV_WAIT);
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    case (op_i)
                        MDU_MULT, MDU_MULTU: begin
                            whilo_c = WriteEnable;
                            hilo_c  = product;
                        end
                        MDU_MADD, MDU_MADDU: begin
                            prod_d  = product;
                            stall_c = Stop;
                            state_d = S_ACC;
                        end
                        MDU_MSUB, MDU_MSUBU: begin
                            prod_d  = ~product + 64'd1;
                            stall_c = Stop;
                            state_d = S_ACC;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            // Operands are latched so the divider sees a stable
                            // request even if the execute-stage inputs move.
                            start_c = DivStart;
                            opa_c   = opa_i;
                            opb_c   = opb_i;
                            sgn_c   = (op_i == MDU_DIV);
                            dopa_d  = opa_i;
                            dopb_d  = opb_i;
                            dsgn_d  = (op_i == MDU_DIV);
                            stall_c = Stop;
                            state_d = S_DIV_WAIT;
                        end
                        default: ;
                    endcase
                end
                S_ACC: begin
                    // hilo_i is taken here, not at issue, to pick up forwarding
                    whilo_c = WriteEnable;
                    hilo_c  = acc_sum;
                    res_d   = acc_sum;
                    state_d = ex_adv_i ? S_IDLE : S_DONE;
                end
                S_DIV_WAIT: begin
                    if (div_ready_i) begin
                        whilo_c = WriteEnable;
                        hilo_c  = div_result_i;
                        res_d   = div_result_i;
                        state_d = ex_adv_i ? S_IDLE : S_DONE;
                    end else begin
                        start_c = DivStart;
                        opa_c   = dopa_q;
                        opb_c   = dopb_q;
                        sgn_c   = dsgn_q;
                        stall_c = Stop;
                    end
                end
                S_DONE: begin
                    whilo_c = WriteEnable;
                    hilo_c  = res_q;
                    if (ex_adv_i) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are forced low while rst is high so that a reset in the middle
    // of an operation is visible before the next clock edge.
    always_comb begin
        stallreq_o   = rst ? 1'b0  : stall_c;
        whilo_o      = rst ? 1'b0  : whilo_c;
        hi_o         = rst ? 32'd0 : hilo_c[63:32];
        lo_o         = rst ? 32'd0 : hilo_c[31:0];
        div_start_o  = rst ? 1'b0  : start_c;
        div_signed_o = rst ? 1'b0  : sgn_c;
        div_opa_o    = rst ? 32'd0 : opa_c;
        div_opb_o    = rst ? 32'd0 : opb_c;
        div_annul_o  = rst ? 1'b0  : annul_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            prod_q  <= 64'd0;
            res_q   <= 64'd0;
            dopa_q  <= 32'd0;
            dopb_q  <= 32'd0;
            dsgn_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prod_q  <= prod_d;
            res_q   <= res_d;
            dopa_q  <= dopa_d;
            dopb_q  <= dopb_d;
            dsgn_q  <= dsgn_d;
        end
    end
endmodule
